// File: rtl/serial_adder_if.sv
// serial_adder_if: request/response bundle for the bit-serial adder.
//   start, a, b  : request from master (sub too when SERIAL_ADDER_SUB_EN is defined)
//   busy, done   : status back to master
//   sum, cout    : held result of the last completed operation
// Parameter WIDTH must match the attached serial_adder instance.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using one full-add cell and a carry flop.
// One operation takes WIDTH RUN cycles plus one DONE cycle; result holds until
// the next completion.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (start/a/b in, busy/done/sum/cout out)
// Optional feature macro SERIAL_ADDER_SUB_EN: adds bus.sub; sub=1 computes a-b
// mod 2^WIDTH with cout reporting borrow.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_c;
    logic             carry_c;
    logic             last_c;
    logic [WIDTH-1:0] b_load_c;
    logic             cin_c;
    logic             cout_fin_c;

`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
`endif

    // Full-add cell on the current LSBs
    always_comb begin
        bit_c   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last_c  = (cnt == CW'(WIDTH - 1));
    end

    // Load values and final carry interpretation (subtract = add ~b + 1, borrow = ~carry)
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load_c   = bus.sub ? ~bus.b : bus.b;
        cin_c      = bus.sub;
        cout_fin_c = sub_q ? ~carry_c : carry_c;
`else
        b_load_c   = bus.b;
        cin_c      = 1'b0;
        cout_fin_c = carry_c;
`endif
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_c)    state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
        end
    end

    // Serial datapath: load on accept, one bit per RUN cycle, publish on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && bus.start) begin
                a_sr  <= bus.a;
                b_sr  <= b_load_c;
                carry <= cin_c;
                cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                sub_q <= bus.sub;
`endif
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr <= {bit_c, res_sr[WIDTH-1:1]};
                carry  <= carry_c;
                cnt    <= cnt + CW'(1);
                if (last_c) begin
                    sum_q  <= {bit_c, res_sr[WIDTH-1:1]};
                    cout_q <= cout_fin_c;
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=8).
// The driver pushes hand-computed {cout,sum} values into a queue; an
// independent monitor pops and compares on every done pulse.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   spur_at = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_exp = 9'h000;
`ifdef SERIAL_ADDER_SUB_EN
    logic op_sub = 1'b0;
`endif

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("result", 32'({bus.cout, bus.sum}), 32'(e));
            end
        end
    end

    // Called at the negedge after the accept edge; n counts edges including the accept edge.
    task automatic wait_done(output int n, output int nb);
        n  = 1;
        nb = (bus.busy === 1'b1) ? 1 : 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) begin
                nb++;
                chk("hold", 32'({bus.cout, bus.sum}), 32'(last_exp));
            end
            if (n == spur_at) begin
                @(negedge clk);
                bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
            end else if (n == spur_at + 1) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_op(input logic [8:0] exp);
        int n;
        int nb;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~bus.a;
        bus.b = ~bus.b;
        wait_done(n, nb);
        chk("latency", 32'(n), 32'(WIDTH + 1));
        chk("busy_cycles", 32'(nb), 32'(WIDTH));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("done_width", 32'(bus.done), 32'd0);
        last_exp = exp;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = op_sub;
`endif
        exp_q.push_back(exp);
        @(posedge clk);
        finish_op(exp);
    endtask

    initial begin
        int n;
        int prev;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h0F, 8'h01, {1'b0, 8'h10});
        do_op(8'hFF, 8'h01, {1'b1, 8'h00});
        do_op(8'hAA, 8'h55, {1'b0, 8'hFF});

        // Spurious start three cycles into RUN must be ignored
        spur_at = 4;
        do_op(8'h22, 8'h33, {1'b0, 8'h55});
        spur_at = 0;
        repeat (15) @(posedge clk);

        // Start held high: back-to-back operations every WIDTH+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
        repeat (3) exp_q.push_back({1'b0, 8'h30});
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (bus.done !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            if (bus.done !== 1'b1) chk("cont_timeout", 32'd0, 32'd1);
            if (k > 0) chk("cont_period", 32'(cyc - prev), 32'(WIDTH + 2));
            prev = cyc;
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        last_exp = {1'b0, 8'h30};
        repeat (12) @(posedge clk);

        // Reset in the fourth RUN cycle aborts; start waiting across reset release
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum",  32'(bus.sum),  32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        last_exp = 9'h000;
        bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04;
        exp_q.push_back({1'b0, 8'h07});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        finish_op({1'b0, 8'h07});

        do_op(8'h80, 8'h80, {1'b1, 8'h00});
        do_op(8'hFF, 8'hFF, {1'b1, 8'hFE});

`ifdef SERIAL_ADDER_SUB_EN
        op_sub = 1'b1;
        do_op(8'h05, 8'h07, {1'b1, 8'hFE});
        do_op(8'h07, 8'h05, {1'b0, 8'h02});
        op_sub = 1'b0;
        do_op(8'h0F, 8'h01, {1'b0, 8'h10});
`endif

        repeat (12) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
